// File: rtl/button_pkg.sv
// Shared types for the push-button front end: per-channel press FSM codes.
package button_pkg;

  localparam int BTN_STATE_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } btn_state_t;

endpackage

// File: rtl/button_channel.sv
// One push-button channel: synchroniser, counter debounce, press FSM and auto-repeat.
module button_channel
  import button_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       btn_raw,
  output logic       level,
  output logic       press,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output btn_state_t state
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic              RAW_IDLE  = (ACTIVE_LOW != 0);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0]  RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0]  RPT_NEXT  = RPT_W'(REPEAT_PERIOD);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   act_p0;
  logic [DB_W-1:0]        db_cnt_p1;
  logic                   level_p1;
  btn_state_t             state_p2;
  logic [RPT_W-1:0]       rpt_cnt_p2;
  logic                   rpt_first_p2;
  logic [RPT_W-1:0]       rpt_tgt_p2;
  logic                   rpt_hit_p2;

  // Counter is bounded by its target: after a pulse it restarts at 1 so the
  // next hit lands exactly one period later, never wrapping on long holds.
  function automatic logic [RPT_W-1:0] rpt_next(input logic [RPT_W-1:0] cnt,
                                                input logic             hit);
    return hit ? RPT_W'(1) : cnt + RPT_W'(1);
  endfunction

  assign act_p0     = (ACTIVE_LOW != 0) ? ~sync_p0[SYNC_STAGES-1] : sync_p0[SYNC_STAGES-1];
  assign rpt_tgt_p2 = rpt_first_p2 ? RPT_FIRST : RPT_NEXT;
  assign rpt_hit_p2 = (state_p2 == HELD) && (rpt_cnt_p2 == rpt_tgt_p2);

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      sync_p0      <= {SYNC_STAGES{RAW_IDLE}};
      db_cnt_p1    <= '0;
      level_p1     <= 1'b0;
      state_p2     <= IDLE;
      rpt_cnt_p2   <= '0;
      rpt_first_p2 <= 1'b1;
    end else begin
      // stage p0: metastability synchroniser
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], btn_raw};

      // stage p1: debounce, level flips after DEBOUNCE_CYCLES straight disagreements
      if (act_p0 == level_p1) begin
        db_cnt_p1 <= '0;
      end else if (db_cnt_p1 == DB_LAST) begin
        level_p1  <= ~level_p1;
        db_cnt_p1 <= '0;
      end else begin
        db_cnt_p1 <= db_cnt_p1 + DB_W'(1);
      end

      // stage p2: press FSM and repeat timer
      case (state_p2)
        IDLE:    state_p2 <= level_p1 ? PRESS : IDLE;
        PRESS:   state_p2 <= level_p1 ? HELD : RELEASE;
        HELD:    state_p2 <= level_p1 ? HELD : RELEASE;
        RELEASE: state_p2 <= level_p1 ? PRESS : IDLE;
        default: state_p2 <= IDLE;
      endcase

      if (state_p2 != HELD) begin
        rpt_cnt_p2   <= '0;
        rpt_first_p2 <= 1'b1;
      end else begin
        rpt_cnt_p2 <= rpt_next(rpt_cnt_p2, rpt_hit_p2);
        if (rpt_hit_p2) rpt_first_p2 <= 1'b0;
      end
    end
  end

  assign level         = level_p1;
  assign state         = state_p2;
  assign press         = (state_p2 == PRESS);
  assign release_pulse = (state_p2 == RELEASE);
  assign repeat_pulse  = (REPEAT_EN != 0) && rpt_hit_p2;

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button front end; independent channels packed onto flat buses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N               = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  input  logic [N-1:0]             btn_raw,
  output logic [N-1:0]             level,
  output logic [N-1:0]             press,
  output logic [N-1:0]             release_pulse,
  output logic [N-1:0]             repeat_pulse,
  output logic [BTN_STATE_W*N-1:0] state
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    btn_state_t ch_state;

    button_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_channel (
      .CLOCK_50      (CLOCK_50),
      .reset_n       (reset_n),
      .btn_raw       (btn_raw[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .state         (ch_state)
    );

    assign state[BTN_STATE_W*i +: BTN_STATE_W] = ch_state;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random presses against a window-based model.
module tb_button_conditioner;

  localparam int N    = 2;
  localparam int S    = 2;
  localparam int D    = 4;
  localparam int DLY  = 8;
  localparam int PER  = 3;
  localparam int MAXE = 4096;

  logic           CLOCK_50 = 1'b0;
  logic           reset_n;
  logic [N-1:0]   btn_raw;
  logic [N-1:0]   level, press, release_pulse, repeat_pulse;
  logic [2*N-1:0] state;

  button_conditioner #(
    .N(N), .ACTIVE_LOW(1), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
    .REPEAT_EN(1), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .btn_raw(btn_raw),
    .level(level), .press(press), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .state(state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int vectors = 0;
  int miscompares = 0;
  int fail_prints = 0;
  int cyc = 0;
  int last_rst = 0;
  int mt, e, code, jh;
  int held_start [N];
  logic [N-1:0] raw_h [MAXE];
  logic [N-1:0] lvl_h [MAXE];
  logic [N-1:0] exp_level, exp_press, exp_rel, exp_rep;
  logic [2*N-1:0] exp_state;
  logic rst_now, flip, a, b;

  // event markers set by the stimulus, read by the checker
  int e0 = -1000, b0 = -1000, b1 = -1000, e1 = -1000, r1 = -1000, rs = -1000;

  // act value seen by the debouncer at edge x: raw from S edges earlier,
  // or the idle level while the synchroniser still holds reset values
  function automatic logic seen(input int x, input int ch);
    if (x - S <= last_rst) return 1'b0;
    return ~raw_h[x-S][ch];
  endfunction

  function automatic logic lv(input int x, input int ch);
    if (x <= last_rst) return 1'b0;
    return lvl_h[x][ch];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      if (fail_prints < 40) $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
      fail_prints++;
    end
  endtask

  // model at each edge, compare on the following falling edge
  initial begin
    for (int i = 0; i < N; i++) held_start[i] = -1;
    forever begin
      @(posedge CLOCK_50);
      mt = cyc + 1;
      cyc = mt;
      raw_h[mt] = btn_raw;
      rst_now = !reset_n;
      if (rst_now) begin
        last_rst = mt;
        lvl_h[mt] = '0;
        exp_press = '0; exp_rel = '0; exp_rep = '0; exp_state = '0;
        for (int ch = 0; ch < N; ch++) held_start[ch] = -1;
      end else begin
        for (int ch = 0; ch < N; ch++) begin
          flip = 1'b1;
          for (int k = 0; k < D; k++) begin
            e = mt - k;
            if (e <= last_rst || seen(e, ch) == lv(mt - 1, ch)) flip = 1'b0;
          end
          lvl_h[mt][ch] = lv(mt - 1, ch) ^ flip;
          a = lv(mt - 1, ch);
          b = lv(mt - 2, ch);
          code = a ? (b ? 2 : 1) : (b ? 3 : 0);
          exp_state[2*ch +: 2] = 2'(code);
          exp_press[ch] = (code == 1);
          exp_rel[ch]   = (code == 3);
          if (code == 2) begin
            if (held_start[ch] < 0) held_start[ch] = mt;
            jh = mt - held_start[ch];
            exp_rep[ch] = (jh == DLY) || (jh > DLY && (jh - DLY) % PER == 0);
          end else begin
            held_start[ch] = -1;
            exp_rep[ch] = 1'b0;
          end
        end
      end
      exp_level = lvl_h[mt];

      @(negedge CLOCK_50);
      check("outputs", {20'd0, level, press, release_pulse, repeat_pulse, state},
            {20'd0, exp_level, exp_press, exp_rel, exp_rep, exp_state});
      if (rst_now)
        check("reset_zero", {20'd0, level, press, release_pulse, repeat_pulse, state}, 32'd0);
      if (cyc == e0 + 4) check("press_lvl_early", level[0], 0);
      if (cyc == e0 + 5) check("press_lvl_rise", level[0], 1);
      if (cyc == e0 + 6) check("press_state", {state[1:0], press[0], level[1]}, {2'd1, 1'b1, 1'b0});
      if (cyc == e0 + 7) check("press_to_held", {state[1:0], press[0]}, {2'd2, 1'b0});
      if (cyc >= b0 && cyc <= b1 + 8)
        check("bounce_quiet", {level[0], press[0], release_pulse[0]}, 0);
      if (cyc == e1 + 14) check("rep_before", repeat_pulse[1], 0);
      if (cyc == e1 + 15) check("rep_first", repeat_pulse[1], 1);
      if (cyc == e1 + 16) check("rep_after", repeat_pulse[1], 0);
      if (cyc == e1 + 17) check("rep_gap", repeat_pulse[1], 0);
      if (cyc == e1 + 18) check("rep_second", repeat_pulse[1], 1);
      if (cyc == e1 + 21) check("rep_third", repeat_pulse[1], 1);
      if (cyc == e1 + 24) check("rep_fourth", repeat_pulse[1], 1);
      if (cyc == r1 + 5) check("rel_still_held", {state[3:2], level[1]}, {2'd2, 1'b0});
      if (cyc == r1 + 6)
        check("rel_state", {state[3:2], release_pulse[1], repeat_pulse[1]}, {2'd3, 1'b1, 1'b0});
      if (cyc == r1 + 7) check("rel_idle", {state[3:2], release_pulse[1]}, {2'd0, 1'b0});
      if (cyc == rs + 6) check("rst_repress_early", state[1:0], 0);
      if (cyc == rs + 7) check("rst_repress", {state[1:0], press[0]}, {2'd1, 1'b1});
    end
  end

  int hold_left [N];

  initial begin
    reset_n = 1'b0;
    btn_raw = 2'b11;
    repeat (3) @(negedge CLOCK_50);
    btn_raw = 2'b00;
    repeat (2) @(negedge CLOCK_50);
    btn_raw = 2'b11;
    reset_n = 1'b1;
    repeat (10) @(negedge CLOCK_50);

    // clean press on channel 0
    btn_raw[0] = 1'b0;
    e0 = cyc + 1;
    repeat (20) @(negedge CLOCK_50);
    btn_raw[0] = 1'b1;
    repeat (15) @(negedge CLOCK_50);

    // bounce: 2-cycle toggles never reach the debounce count
    b0 = cyc + 1;
    b1 = b0 + 20;
    for (int i = 0; i < 10; i++) begin
      btn_raw[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge CLOCK_50);
    end
    btn_raw[0] = 1'b1;
    repeat (12) @(negedge CLOCK_50);

    // long hold on channel 1, then release
    btn_raw[1] = 1'b0;
    e1 = cyc + 1;
    repeat (40) @(negedge CLOCK_50);
    btn_raw[1] = 1'b1;
    r1 = cyc + 1;
    repeat (15) @(negedge CLOCK_50);

    // reset while channel 0 is held
    btn_raw[0] = 1'b0;
    repeat (15) @(negedge CLOCK_50);
    reset_n = 1'b0;
    rs = cyc + 1;
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    btn_raw[0] = 1'b1;
    repeat (10) @(negedge CLOCK_50);

    // random holds of 1..14 cycles with occasional resets
    for (int i = 0; i < N; i++) hold_left[i] = 0;
    for (int n = 0; n < 1500; n++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      for (int ch = 0; ch < N; ch++) begin
        if (hold_left[ch] == 0) begin
          btn_raw[ch] = ($urandom_range(0, 1) == 1);
          hold_left[ch] = $urandom_range(1, 14);
        end
        hold_left[ch]--;
      end
      @(negedge CLOCK_50);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Parametrised N-channel push-button front end for the game and VGA top level. It replaces the single-channel press/held/release detector. Each channel provides:
- metastability synchronisation
- counter-based debounce
- a 4-state press FSM
- one-cycle press, release and auto-repeat pulses

The paddle and ball logic consume the pulses and levels. The per-channel state code keeps the existing 2-bit encoding.

Parameters:
N, 4, number of button channels (>=1)
ACTIVE_LOW, 1, 1 = raw input pressed when 0 (board KEYs); 0 = pressed when 1
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 250000, consecutive clocks of disagreement before the debounced level flips (>=1; 5 ms at 50 MHz)
REPEAT_EN, 1, 0 disables the repeat output (tied 0)
REPEAT_DELAY, 25000000, HELD cycle index of the first repeat pulse (>=1)
REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (>=1)

Ports:
CLOCK_50  in  1  system clock, all logic on posedge
reset_n  in  1  synchronous, active-low reset
btn_raw  in  N  asynchronous raw button inputs
level  out  N  debounced pressed level, 1 = pressed
press  out  N  one-cycle pulse on debounced press
release  out  N  one-cycle pulse on debounced release
repeat  out  N  one-cycle auto-repeat pulses while held
state  out  2N  per-channel FSM code; channel i at [2i+1:2i]

Behaviour:
- Clock and reset: one clock, CLOCK_50; reset is synchronous and active-low (reset_n). Reset has priority over all other updates.
- Values held in reset:
  - all outputs 0, state codes 0 (IDLE)
  - synchroniser flops at the inactive raw level (1 if ACTIVE_LOW)
  - all counters 0
- Channels are fully independent; no cross-channel interaction.
- Synchroniser: btn_raw[i] passes through SYNC_STAGES flops. act = ACTIVE_LOW ? ~sync_out : sync_out.
- Debounce:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Any cycle with act == level clears the counter.
  - Otherwise the counter increments. When the incremented value equals DEBOUNCE_CYCLES, level toggles and the counter clears that same edge.
  - The counter never wraps.
- FSM, per channel, registered (codes IDLE=0, PRESS=1, HELD=2, RELEASE=3):
  - IDLE: level=1 -> PRESS, else stay.
  - PRESS, exactly one cycle: level=1 -> HELD; level=0 -> RELEASE.
  - HELD: level=0 -> RELEASE, else stay.
  - RELEASE, exactly one cycle: level=1 -> PRESS; level=0 -> IDLE.
- Output decode:
  - press = (state==PRESS)
  - release = (state==RELEASE)
  - both are decoded from registered state, so they are glitch-free.
- Latency: with raw held steady from the first sampling edge E, the sequence is:
  - level rises at edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1
  - state becomes PRESS at edge E+SYNC_STAGES+DEBOUNCE_CYCLES
  - press is high for exactly the following cycle
  - release timing is symmetric.
- Repeat:
  - HELD cycle 0 is the first cycle with state==HELD. The repeat counter clears on every non-HELD cycle.
  - repeat is high for one cycle at HELD cycle REPEAT_DELAY, then at REPEAT_DELAY+k*REPEAT_PERIOD for k>=1.
  - repeat is never high in PRESS, RELEASE or IDLE.
  - The counter saturates, then reloads per period, so there is no wrap artefact on arbitrarily long holds.
  - When REPEAT_EN=0, repeat is constant 0.
- Reset mid-operation: all state is discarded at the next edge. If the button is still held afterwards, the full sync+debounce latency applies again and a fresh press pulse is produced.
- Bounce shorter than DEBOUNCE_CYCLES: no change to level and no pulses.

Decomposition:
- Package button_pkg holds:
  - typedef enum logic [1:0] btn_state_t {IDLE, PRESS, HELD, RELEASE}
  - localparam BTN_STATE_W = 2
- Sub-module button_channel holds one channel (sync, debounce, FSM, repeat) with the same parameters minus N. The top level instantiates it N times in a generate loop and packs the outputs.

Test Plan:
Bench parameters: N=2, ACTIVE_LOW=1, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
1. Reset: reset_n=0 for 3 clocks, btn_raw=2'b11 -> level/press/release/repeat=0 and state=4'b0000 every cycle; the same holds with btn_raw=2'b00 during reset.
2. Clean press: btn_raw[0] 1->0 before edge E, held -> level[0]=1 at E+5, state[1:0]=1 at E+6, press[0] high one cycle only, then state=2; channel 1 untouched.
3. Bounce: btn_raw[0] toggles every 2 cycles for 20 cycles, then returns to 1 -> level[0] stays 0, no press/release pulse.
4. Auto-repeat: hold btn_raw[1]=0 long after press -> repeat[1] one-cycle pulses at HELD cycles 8, 11, 14, 17…; none before cycle 8.
5. Release: after test 4, btn_raw[1]->1 at edge R -> state=3 at R+6, release[1] one cycle, then state=0; repeat[1] stops immediately.
6. Reset mid-hold: reset_n=0 for one edge while channel 0 is HELD, button still pressed -> outputs 0 next edge; after reset_n=1, press[0] reasserts after the full 2+4 latency.
